merger_tree_p16_l16: RTL and testbench



---
 rtl/merger_tree_p16_l16.sv | 129 ++++++++++++
 tb/tb_merger_tree_p16_l16.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/merger_tree_p16_l16.sv
// merger_tree_p16_l16: merges 32 sorted leaf streams through a 31-node binary tree, packing 16 records per output beat
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_fifo            32 leaf FWFT heads, leaf k at [k*DW +: DW]
//   i_fifo_empty      leaf k FIFO empty
//   i_fifo_out_ready  sink accepts a beat this cycle
//   o_fifo_read       pop leaf k this cycle
//   o_out_fifo_write  o_data valid, write to sink
//   o_data            16 records, record 0 first in sort order
// Optional: MERGER_TREE_ORDER_CHECK_EN adds a simulation-only ordering / handshake check.
module merger_tree_p16_l16 #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [32*DATA_WIDTH-1:0] i_fifo,
    input  logic [31:0]             i_fifo_empty,
    input  logic                    i_fifo_out_ready,
    output logic [31:0]             o_fifo_read,
    output logic                    o_out_fifo_write,
    output logic [16*DATA_WIDTH-1:0] o_data
);
    localparam int P = 16;
    localparam int L = 16;
    localparam int N = 2 * L;
    localparam int B = 2 * N;
    // Buffers form a heap: node n merges buffers 2n (A) and 2n+1 (B) into buffer n.
    // Leaf k feeds buffer N+k; the packer drains buffer 1.
    logic [DATA_WIDTH-1:0] hd [1:B-1];
    logic [DATA_WIDTH-1:0] tl [1:B-1];
    logic [1:0]            cnt [1:B-1];
    logic                  pop [1:B-1];
    logic                  push [1:B-1];
    logic [DATA_WIDTH-1:0] din [1:B-1];
    logic                  term [1:B-1];
    logic                  fire [1:N-1];
    logic                  le [1:N-1];
    logic [DATA_WIDTH-1:0] slot [P];
    logic [4:0]            fill;
    logic                  take;

    assign o_out_fifo_write = (fill == 5'(P)) && i_fifo_out_ready;
    assign take = (cnt[1] != 2'd0) && ((fill != 5'(P)) || i_fifo_out_ready);

    always_comb begin
        o_fifo_read = '0;
        for (int i = 1; i < B; i++) begin
            pop[i]  = 1'b0;
            push[i] = 1'b0;
            din[i]  = '0;
            term[i] = hd[i][KEY_WIDTH-1:0] == '0;
        end
        for (int k = 0; k < N; k++) begin
            o_fifo_read[k] = i_rst_n & ~i_fifo_empty[k] & (cnt[N+k] != 2'd2);
            push[N+k]      = o_fifo_read[k];
            din[N+k]       = i_fifo[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int n = 1; n < N; n++) begin
            fire[n] = (cnt[2*n] != 2'd0) && (cnt[2*n+1] != 2'd0) && (cnt[n] != 2'd2);
            le[n]   = hd[2*n][KEY_WIDTH-1:0] <= hd[2*n+1][KEY_WIDTH-1:0];
            // A terminator on one side yields to the other side until both are terminators.
            pop[2*n]   = fire[n] && (term[2*n+1] || (!term[2*n] && le[n]));
            pop[2*n+1] = fire[n] && (term[2*n] || (!term[2*n+1] && !le[n]));
            push[n]    = fire[n];
            din[n]     = pop[2*n] ? hd[2*n] : hd[2*n+1];
        end
        pop[1] = take;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < B; i++) begin
                hd[i]  <= '0;
                tl[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < B; i++) begin
                if (pop[i])
                    hd[i] <= (cnt[i] == 2'd2) ? tl[i] : din[i];
                else if (push[i] && cnt[i] == 2'd0)
                    hd[i] <= din[i];
                if (push[i] && cnt[i] == (pop[i] ? 2'd2 : 2'd1))
                    tl[i] <= din[i];
                cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // A full beat leaving this cycle frees slot 0 for the record taken in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill <= '0;
            for (int j = 0; j < P; j++) slot[j] <= '0;
        end else begin
            if (take) slot[o_out_fifo_write ? 4'd0 : fill[3:0]] <= hd[1];
            fill <= o_out_fifo_write ? {4'd0, take} : fill + {4'd0, take};
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_out
        assign o_data[j*DATA_WIDTH +: DATA_WIDTH] = slot[j];
    end

`ifdef MERGER_TREE_ORDER_CHECK_EN
    logic [KEY_WIDTH-1:0] last_key;
    always @(posedge i_clk or negedge i_rst_n) begin
        logic [KEY_WIDTH-1:0] k;
        logic [KEY_WIDTH-1:0] cur;
        if (!i_rst_n) begin
            last_key <= '0;
        end else if (o_out_fifo_write) begin
            if (!i_fifo_out_ready) $error("beat written while sink not ready");
            k = last_key;
            for (int j = 0; j < P; j++) begin
                cur = o_data[j*DATA_WIDTH +: KEY_WIDTH];
                if (cur == '0) begin
                    k = '0;
                end else begin
                    if (cur < k) $error("key %0h below previous %0h", cur, k);
                    k = cur;
                end
            end
            last_key <= k;
        end
    end
`endif
endmodule

// File: tb/tb_merger_tree_p16_l16.sv
// tb_merger_tree_p16_l16: directed checks of the 32-leaf merge tree with a leaf FIFO and sink model
module tb_merger_tree_p16_l16;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1023:0] fifo = '0;
    logic [31:0]   empty = '1;
    logic          ready = 1'b1;
    logic [31:0]   rd;
    logic          wr;
    logic [511:0]  data;

    always #5 clk = ~clk;

    merger_tree_p16_l16 #(.DATA_WIDTH(32), .KEY_WIDTH(16)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_fifo(fifo),
        .i_fifo_empty(empty),
        .i_fifo_out_ready(ready),
        .o_fifo_read(rd),
        .o_out_fifo_write(wr),
        .o_data(data)
    );

    logic [31:0] lq [32][$];
    logic [31:0] oq [$];
    logic [31:0] ex [$];
    logic [31:0] rd_s = '0;
    int checks = 0, errors = 0, cyc = 0, rmode = 0, beats = 0, bad_wr = 0;
    bit hold7 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaf FIFOs and sink: inputs change on negedge, reads/writes are sampled before the next posedge.
    always @(negedge clk) begin
        if (rst_n)
            for (int k = 0; k < 32; k++)
                if (rd_s[k] && lq[k].size() > 0) void'(lq[k].pop_front());
        cyc++;
        ready = (rmode == 0) || (rmode == 1 && cyc % 100 < 30);
        for (int k = 0; k < 32; k++) begin
            empty[k] = lq[k].size() == 0 || (hold7 && k == 7);
            fifo[k*32 +: 32] = '0;
            if (!empty[k]) fifo[k*32 +: 32] = lq[k][0];
        end
        #1;
        rd_s = rst_n ? rd : '0;
        if (wr) begin
            beats++;
            if (!ready) bad_wr++;
            for (int j = 0; j < 16; j++) oq.push_back(data[j*32 +: 32]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_on();
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++) lq[k].delete();
        oq.delete();
        ex.delete();
        beats = 0;
        bad_wr = 0;
        hold7 = 1'b0;
        rmode = 0;
        #1;
    endtask

    task automatic gen(input int n, input int runs, input int base);
        logic [31:0] v;
        for (int k = 0; k < 32; k++)
            for (int r = 0; r < runs; r++) begin
                v = base;
                repeat (n) begin
                    v += $urandom_range(1, 50);
                    lq[k].push_back(v);
                end
                lq[k].push_back(0);
            end
    endtask

    task automatic build_exp();
        logic [31:0] rq [20][$];
        int nr = 0;
        for (int k = 0; k < 32; k++) begin
            int r = 0;
            for (int i = 0; i < lq[k].size(); i++)
                if (lq[k][i] == 0) r++;
                else rq[r].push_back(lq[k][i]);
            if (r > nr) nr = r;
        end
        for (int r = 0; r < nr; r++) begin
            rq[r].sort();
            for (int i = 0; i < rq[r].size(); i++) ex.push_back(rq[r][i]);
            ex.push_back(0);
        end
    endtask

    task automatic wait_recs(input int n, input int limit);
        int t = 0;
        while (oq.size() < n && t < limit) begin
            tick(1);
            t++;
        end
    endtask

    task automatic wait_stream(input string tag, input int limit);
        int n = (ex.size() / 16) * 16;
        int mm = 0;
        wait_recs(n, limit);
        chk({tag, " recs"}, 64'(oq.size() >= n), 1);
        for (int i = 0; i < n && i < oq.size(); i++)
            if (oq[i] !== ex[i]) mm++;
        chk({tag, " order"}, 64'(mm), 0);
    endtask

    initial begin
        int mm, bad;
        logic [511:0] snap;
        tick(2);
        reset_on();
        gen(20, 1, 0);
        build_exp();
        tick(2);
        chk("rst wr", 64'(wr), 0);
        chk("rst rd", 64'(rd), 0);
        chk("rst data", 64'(|data), 0);
        rst_n = 1'b1;
        wait_stream("basic", 2000);

        reset_on();
        gen(20, 1, 0);
        rst_n = 1'b1;
        tick(40);
        reset_on();
        chk("midrst wr", 64'(wr), 0);
        chk("midrst rd", 64'(rd), 0);
        chk("midrst data", 64'(|data), 0);
        gen(20, 1, 10000);
        build_exp();
        tick(3);
        rst_n = 1'b1;
        wait_stream("postrst", 2000);

        reset_on();
        for (int k = 0; k < 32; k++) begin
            lq[k].push_back(32 - k);
            repeat (16) lq[k].push_back(0);
        end
        tick(2);
        rst_n = 1'b1;
        wait_recs(48, 500);
        tick(30);
        for (int i = 0; i < 48; i++)
            chk($sformatf("desc rec%0d", i), (i < oq.size()) ? 64'(oq[i]) : 64'hdead, (i < 32) ? 64'(i + 1) : 64'd0);
        chk("desc beats", 64'(beats), 3);

        reset_on();
        for (int k = 0; k < 32; k++) begin
            repeat (16) lq[k].push_back({k[15:0], 16'd5});
            lq[k].push_back(0);
        end
        tick(2);
        rst_n = 1'b1;
        wait_recs(512, 2000);
        tick(30);
        mm = 0;
        for (int i = 0; i < 512; i++)
            if (i >= oq.size() || oq[i] !== {16'(i / 16), 16'd5}) mm++;
        chk("dup order", 64'(mm), 0);
        chk("dup beats", 64'(beats), 32);

        reset_on();
        gen(20, 1, 0);
        build_exp();
        hold7 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(50);
        chk("hold7 beats", 64'(beats), 0);
        chk("hold7 rd", 64'(rd), 0);
        hold7 = 1'b0;
        wait_stream("hold7", 2000);

        reset_on();
        gen(20, 1, 0);
        build_exp();
        rmode = 2;
        tick(2);
        rst_n = 1'b1;
        tick(50);
        snap = data;
        bad = 0;
        repeat (150) begin
            tick(1);
            if (data !== snap || wr) bad++;
        end
        chk("stall hold", 64'(bad), 0);
        chk("stall rd", 64'(rd), 0);
        chk("stall wr", 64'(bad_wr), 0);
        rmode = 0;
        wait_stream("stall", 2000);

        reset_on();
        gen(100, 2, 0);
        build_exp();
        rmode = 1;
        tick(2);
        rst_n = 1'b1;
        wait_stream("bulk", 40000);
        chk("bulk wr ready", 64'(bad_wr), 0);
        rmode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
